// File: rtl/pll_lock_detect.sv
// pll_lock_detect
//   Lock detector for the PLL. Takes one frequency/phase measurement per
//   refclk cycle and walks UNLOCKED -> FREQ_LOCKED -> PHASE_LOCKED as
//   consecutive good samples accumulate. It drops back to UNLOCKED after
//   repeated bad samples or a change of divn, and pulses lock_lost on exit.
//   Optional feature: define LOCK_LOSS_CNT_EN to add the loss_cnt output,
//   a saturating count of lock_lost pulses.
module pll_lock_detect #(
  parameter int CW          = 8,
  parameter int PHASE_W     = 8,
  parameter int FREQ_TOL    = 1,
  parameter int PHASE_TOL   = 4,
  parameter int FREQ_HOLD   = 16,
  parameter int PHASE_HOLD  = 32,
  parameter int UNLOCK_MISS = 4
) (
  input  logic               refclk,
  input  logic               resetn,
  input  logic [CW-1:0]      divn,
  input  logic               meas_valid,
  input  logic [CW-1:0]      fb_count,
  input  logic [PHASE_W-1:0] phase_err,
  output logic [1:0]         lock_state,
  output logic               freq_ok,
  output logic               phase_ok,
`ifdef LOCK_LOSS_CNT_EN
  output logic [7:0]         loss_cnt,
`endif
  output logic               lock_lost
);

  typedef enum logic [1:0] {
    UNLOCKED     = 2'd0,
    FREQ_LOCKED  = 2'd1,
    PHASE_LOCKED = 2'd2
  } lock_state_t;

  localparam int HOLD_MAX_N = (FREQ_HOLD > PHASE_HOLD) ? FREQ_HOLD : PHASE_HOLD;
  localparam int HOLD_W     = $clog2(HOLD_MAX_N) + 1;
  localparam int MISS_W     = $clog2(UNLOCK_MISS) + 1;

  localparam logic [HOLD_W-1:0]  FREQ_HOLD_V   = HOLD_W'(FREQ_HOLD);
  localparam logic [HOLD_W-1:0]  PHASE_HOLD_V  = HOLD_W'(PHASE_HOLD);
  localparam logic [MISS_W-1:0]  UNLOCK_MISS_V = MISS_W'(UNLOCK_MISS);
  localparam logic [CW:0]        FREQ_TOL_V    = (CW+1)'(FREQ_TOL);
  localparam logic [PHASE_W-1:0] PHASE_TOL_V   = PHASE_W'(PHASE_TOL);
  localparam logic [PHASE_W-1:0] PHASE_MIN     = {1'b1, {(PHASE_W-1){1'b0}}};
  localparam logic [PHASE_W-1:0] PHASE_MAX     = {1'b0, {(PHASE_W-1){1'b1}}};

  lock_state_t       state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic [MISS_W-1:0] miss_q, miss_d, miss_inc;
  logic [CW-1:0]     divn_q;
  logic              sample_valid;
  logic              lost_d;
  logic              divn_changed;

  logic [CW:0]        freq_diff;
  logic [CW:0]        freq_abs;
  logic               freq_good;
  logic [PHASE_W-1:0] phase_abs;
  logic               phase_good;

  // Frequency difference is taken one bit wider so the sign survives;
  // the most-negative phase error has no positive twin, so it saturates
  // to the largest magnitude and can never pass the tolerance check.
  assign freq_diff  = {1'b0, fb_count} - {1'b0, divn};
  assign freq_abs   = freq_diff[CW] ? (~freq_diff + 1'b1) : freq_diff;
  assign freq_good  = (divn != '0) && (freq_abs <= FREQ_TOL_V);
  assign phase_abs  = (phase_err == PHASE_MIN) ? PHASE_MAX :
                      (phase_err[PHASE_W-1] ? (~phase_err + 1'b1) : phase_err);
  assign phase_good = (phase_abs <= PHASE_TOL_V);

  assign hold_inc     = (hold_q == '1) ? hold_q : hold_q + 1'b1;
  assign miss_inc     = (miss_q == '1) ? miss_q : miss_q + 1'b1;
  assign divn_changed = (divn != divn_q);
  assign lock_state   = state_q;

  // Stage 1: register the per-sample checks; flags hold between valid samples
  always_ff @(posedge refclk or negedge resetn) begin
    if (!resetn) begin
      freq_ok      <= 1'b0;
      phase_ok     <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= meas_valid;
      if (meas_valid) begin
        freq_ok  <= freq_good;
        phase_ok <= phase_good;
      end
    end
  end

  // Stage 2 state register: lock state, hold/miss counters, divn shadow, loss pulse
  always_ff @(posedge refclk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= UNLOCKED;
      hold_q    <= '0;
      miss_q    <= '0;
      divn_q    <= '0;
      lock_lost <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      miss_q    <= miss_d;
      divn_q    <= divn;
      lock_lost <= lost_d;
    end
  end

  // Next-state logic: a divn change overrides everything, otherwise consume the stage-1 sample
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    miss_d  = miss_q;
    lost_d  = 1'b0;
    if (divn_changed) begin
      state_d = UNLOCKED;
      hold_d  = '0;
      miss_d  = '0;
      lost_d  = (state_q != UNLOCKED);
    end else if (sample_valid) begin
      case (state_q)
        UNLOCKED: begin
          if (!freq_ok) begin
            hold_d = '0;
          end else if (hold_inc == FREQ_HOLD_V) begin
            state_d = FREQ_LOCKED;
            hold_d  = '0;
          end else begin
            hold_d = hold_inc;
          end
        end
        FREQ_LOCKED: begin
          if (!freq_ok) begin
            state_d = UNLOCKED;
            hold_d  = '0;
            lost_d  = 1'b1;
          end else if (!phase_ok) begin
            hold_d = '0;
          end else if (hold_inc == PHASE_HOLD_V) begin
            state_d = PHASE_LOCKED;
            hold_d  = '0;
          end else begin
            hold_d = hold_inc;
          end
        end
        PHASE_LOCKED: begin
          if (freq_ok && phase_ok) begin
            miss_d = '0;
          end else if (miss_inc == UNLOCK_MISS_V) begin
            state_d = UNLOCKED;
            hold_d  = '0;
            miss_d  = '0;
            lost_d  = 1'b1;
          end else begin
            miss_d = miss_inc;
          end
        end
        default: begin
          state_d = UNLOCKED;
          hold_d  = '0;
          miss_d  = '0;
        end
      endcase
    end
  end

`ifdef LOCK_LOSS_CNT_EN
  // Count lock-loss events, sticking at the top of the range
  always_ff @(posedge refclk or negedge resetn) begin
    if (!resetn) begin
      loss_cnt <= '0;
    end else if (lost_d && (loss_cnt != 8'hFF)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end
`endif

endmodule
